// File: rtl/dm_bus_adapter.sv
// ---------------------------------------------------------------------------
// dm_bus_adapter
//
// Bridges a single-cycle core request strobe onto a debug-memory slave port.
// Accesses inside the debug-memory window are forwarded as a one-cycle slave
// request, and the read data is returned three cycles after the strobe.
// Accesses outside the window complete one cycle after the strobe with err_o
// set. A strobe that arrives while an access is still in flight is dropped and
// latches the sticky overrun_o flag.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   strobe_i       one-cycle core request pulse
//   addr_i         core byte address
//   rw_i           1 = write, 0 = read
//   byte_enable_i  write byte lanes
//   data_i         write data
//   data_o         read data to the core (0 for writes and errors)
//   data_ready_o   one-cycle completion pulse
//   err_o          access was outside the window (only with data_ready_o)
//   overrun_o      sticky: a strobe was dropped while busy
//   slave_req_o    one-cycle debug-memory request
//   slave_we_o     debug-memory write enable
//   slave_addr_o   word-aligned debug-memory address
//   slave_be_o     debug-memory byte enables
//   slave_wdata_o  debug-memory write data
//   slave_rdata_i  debug-memory read data, valid the cycle after slave_req_o
// ---------------------------------------------------------------------------
module dm_bus_adapter #(
    parameter int                  BusWidth      = 32,
    parameter logic [BusWidth-1:0] DmBaseAddress = 'h1000,
    parameter logic [BusWidth-1:0] DmSize        = 'h1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    strobe_i,
    input  logic [BusWidth-1:0]     addr_i,
    input  logic                    rw_i,
    input  logic [BusWidth/8-1:0]   byte_enable_i,
    input  logic [BusWidth-1:0]     data_i,
    output logic [BusWidth-1:0]     data_o,
    output logic                    data_ready_o,
    output logic                    err_o,
    output logic                    overrun_o,
    output logic                    slave_req_o,
    output logic                    slave_we_o,
    output logic [BusWidth-1:0]     slave_addr_o,
    output logic [BusWidth/8-1:0]   slave_be_o,
    output logic [BusWidth-1:0]     slave_wdata_o,
    input  logic [BusWidth-1:0]     slave_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Window bounds are kept one bit wider than the bus so that a window
    // ending exactly at the top of the address space does not wrap to zero.
    localparam logic [BusWidth:0] WindowLow  = {1'b0, DmBaseAddress};
    localparam logic [BusWidth:0] WindowHigh = {1'b0, DmBaseAddress} + {1'b0, DmSize};

    state_t state;
    state_t next_state;

    logic                  in_window;
    logic [BusWidth-1:0]   next_data;
    logic                  next_ready;
    logic                  next_err;
    logic                  next_overrun;
    logic                  next_req;
    logic                  next_we;
    logic [BusWidth-1:0]   next_addr;
    logic [BusWidth/8-1:0] next_be;
    logic [BusWidth-1:0]   next_wdata;

    assign in_window = ({1'b0, addr_i} >= WindowLow) && ({1'b0, addr_i} < WindowHigh);

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output takes in the cycle after the edge.
    // The slave request fields double as the captured request: slave_we_o
    // tells WAIT whether the access was a write.
    always_comb begin
        next_state   = state;
        next_data    = data_o;
        next_ready   = 1'b0;
        next_err     = 1'b0;
        next_overrun = overrun_o;
        next_req     = 1'b0;
        next_we      = slave_we_o;
        next_addr    = slave_addr_o;
        next_be      = slave_be_o;
        next_wdata   = slave_wdata_o;

        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (strobe_i) begin
                    if (in_window) begin
                        next_state = ISSUE;
                        next_req   = 1'b1;
                        next_we    = rw_i;
                        next_addr  = {addr_i[BusWidth-1:2], 2'b00};
                        next_be    = byte_enable_i;
                        next_wdata = data_i;
                    end else begin
                        next_state = DONE;
                        next_ready = 1'b1;
                        next_err   = 1'b1;
                        next_data  = '0;
                    end
                end
            end
            ISSUE: begin
                next_state = WAIT;
                if (strobe_i) begin
                    next_overrun = 1'b1;
                end
            end
            WAIT: begin
                next_state = DONE;
                next_ready = 1'b1;
                next_data  = slave_we_o ? '0 : slave_rdata_i;
                if (strobe_i) begin
                    next_overrun = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State and output registers. Reset has priority over everything,
    // including a strobe arriving in the same cycle, and abandons any access
    // in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            data_o        <= '0;
            data_ready_o  <= 1'b0;
            err_o         <= 1'b0;
            overrun_o     <= 1'b0;
            slave_req_o   <= 1'b0;
            slave_we_o    <= 1'b0;
            slave_addr_o  <= '0;
            slave_be_o    <= '0;
            slave_wdata_o <= '0;
        end else begin
            state         <= next_state;
            data_o        <= next_data;
            data_ready_o  <= next_ready;
            err_o         <= next_err;
            overrun_o     <= next_overrun;
            slave_req_o   <= next_req;
            slave_we_o    <= next_we;
            slave_addr_o  <= next_addr;
            slave_be_o    <= next_be;
            slave_wdata_o <= next_wdata;
        end
    end

endmodule

// File: doc/dm_bus_adapter.md
DM_BUS_ADAPTER -- requirements
Module: dm_bus_adapter

Interface
REQ-001 The block SHALL have parameter BusWidth, default 32, meaning data/address width in bits.
REQ-002 The block SHALL have parameter DmBaseAddress, default 'h1000, meaning the first byte address of the debug memory window.
REQ-003 The block SHALL have parameter DmSize, default 'h1000, meaning the window size in bytes.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1, system clock.
REQ-006 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port strobe_i, input, 1, one-cycle core request pulse.
REQ-008 The block SHALL have port addr_i, input, BusWidth, core byte address.
REQ-009 The block SHALL have port rw_i, input, 1, 1 = write and 0 = read.
REQ-010 The block SHALL have port byte_enable_i, input, BusWidth/8, write byte lanes.
REQ-011 The block SHALL have port data_i, input, BusWidth, write data.
REQ-012 The block SHALL have port data_o, output, BusWidth, read data to the core.
REQ-013 The block SHALL have port data_ready_o, output, 1, one-cycle completion pulse.
REQ-014 The block SHALL have port err_o, output, 1, access outside the window; valid with data_ready_o.
REQ-015 The block SHALL have port overrun_o, output, 1, sticky flag: strobe dropped while busy.
REQ-016 The block SHALL have ports slave_req_o (output, 1), slave_we_o (output, 1), slave_addr_o (output, BusWidth), slave_be_o (output, BusWidth/8) and slave_wdata_o (output, BusWidth), which form the debug-memory request.
REQ-017 The block SHALL have port slave_rdata_i, input, BusWidth, debug-memory read data, valid the cycle after slave_req_o.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
REQ-019 A strobe SHALL be accepted only in IDLE or DONE; on acceptance, addr_i, rw_i, byte_enable_i and data_i SHALL be captured.
REQ-020 An address is in the window iff DmBaseAddress <= addr_i < DmBaseAddress+DmSize; the comparison is unsigned, at BusWidth+1 bits to avoid overflow.
REQ-021 An in-window accept SHALL go to ISSUE, which drives slave_req_o=1 for exactly one cycle, with slave_addr_o = captured address with bits [1:0] forced to 0, and slave_we_o/slave_be_o/slave_wdata_o = captured values.
REQ-022 ISSUE SHALL always go to WAIT; WAIT SHALL register slave_rdata_i into data_o for reads, or set data_o to 0 for writes, and go to DONE.
REQ-023 In DONE, data_ready_o SHALL be 1 for one cycle; the next state is ISSUE/DONE if a strobe is accepted, else IDLE.
REQ-024 In-window latency: strobe in cycle N -> slave_req_o in N+1 -> rdata sampled in N+2 -> data_ready_o in N+3; back-to-back throughput is one access per 3 cycles.
REQ-025 An out-of-window accept SHALL go directly to DONE with err_o=1 and data_o=0, SHALL NOT assert slave_req_o, and SHALL have a latency of 1 cycle.
REQ-026 err_o SHALL be 0 whenever data_ready_o is 0.
REQ-027 A strobe in ISSUE or WAIT SHALL be ignored (no state or data change) and SHALL set overrun_o=1, which is held until reset.
REQ-028 slave_req_o SHALL be 0 in every state except ISSUE; the slave_* fields SHALL hold their last values otherwise.
REQ-029 Boundary: addr_i = DmBaseAddress+DmSize-1 SHALL be in window; addr_i = DmBaseAddress+DmSize and DmBaseAddress-1 SHALL be out of window.

Reset
REQ-030 When rst_i=1 at a clock edge, the state SHALL become IDLE, and data_o, slave_addr_o, slave_wdata_o, slave_be_o, slave_req_o, slave_we_o, data_ready_o, err_o and overrun_o SHALL all become 0.
REQ-031 Reset in ISSUE, WAIT or DONE SHALL abandon the access, with no data_ready_o pulse afterwards.
REQ-032 A strobe coinciding with rst_i=1 SHALL be ignored.

Verification
REQ-033 Read: strobe, addr 'h1104, rw 0; slave_rdata_i='hDEADBEEF in N+2 -> slave_req_o only in N+1 with slave_addr_o='h1104 and we=0; data_ready_o in N+3 with data_o='hDEADBEEF and err_o=0.
REQ-034 Write: strobe, addr 'h1003, be 4'b0011, data 'h12345678 -> N+1: slave_we_o=1, slave_addr_o='h1000, slave_be_o=4'b0011, slave_wdata_o='h12345678; N+3: ready with data_o=0.
REQ-035 Window edges: addr 'h1FFC -> slave_req_o pulse; addr 'h2000 and 'h0FFC -> data_ready_o in N+1 with err_o=1 and no slave_req_o.
REQ-036 Busy strobe: strobe in N, second strobe in N+1 -> one slave_req_o only and overrun_o=1; strobe in the DONE cycle N+3 -> accepted, slave_req_o in N+4, overrun_o unchanged.
REQ-037 Reset mid-access: strobe in N, rst_i=1 in N+2 -> no data_ready_o in N+3, all outputs 0, next strobe serviced normally.
